// File: rtl/fv_sb_wolper_mc.sv
// fv_sb_wolper_mc: scoreboard monitor for two tracked symbols (A, B) moving
// through NCH push/pop channel pairs. Each symbol runs its own
// IDLE -> IN_FLIGHT -> DONE tracker; violations latch into sticky flags.
// Optional macro FV_SB_WOLPER_ASSERT_EN compiles in formal properties.

// Per-symbol tracker: decodes channel hits for one symbol, keeps its state
// and latency counter, and reports which flag conditions fire this cycle.
module fv_sb_wolper_trk #(
    parameter int DWIDTH  = 4,
    parameter int NCH     = 2,
    parameter int MAX_LAT = 16,
    parameter int SCW     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DWIDTH-1:0]     sym,
    input  logic [SCW-1:0]        sym_ch,
    input  logic [NCH-1:0]        push_valid,
    input  logic [NCH*DWIDTH-1:0] push_data,
    input  logic [NCH-1:0]        pop_valid,
    input  logic [NCH*DWIDTH-1:0] pop_data,
    output logic                  in_flight,
    output logic                  push_ok,
    output logic                  pop_ok,
    output logic                  pop_other,
    output logic                  set_causality,
    output logic                  set_dup,
    output logic                  set_latency,
    output logic                  set_env
);
    typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_DONE} st_t;

    st_t        st;
    logic [7:0] lat;
    logic       push_hit, push_other, pop_hit;

    // Split every strobe carrying this symbol into "on sym_ch" and "elsewhere".
    always_comb begin
        push_hit   = 1'b0;
        push_other = 1'b0;
        pop_hit    = 1'b0;
        pop_other  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (push_valid[i] && push_data[i*DWIDTH +: DWIDTH] == sym) begin
                if (i == int'(sym_ch)) push_hit = 1'b1;
                else                   push_other = 1'b1;
            end
            if (pop_valid[i] && pop_data[i*DWIDTH +: DWIDTH] == sym) begin
                if (i == int'(sym_ch)) pop_hit = 1'b1;
                else                   pop_other = 1'b1;
            end
        end
    end

    // State and latency counter; a pop in the push cycle sees IDLE and so
    // never completes the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            st  <= S_IDLE;
            lat <= 8'd0;
        end else begin
            case (st)
                S_IDLE: if (push_hit) begin
                    st  <= S_FLIGHT;
                    lat <= 8'd0;
                end
                S_FLIGHT: begin
                    if (pop_hit)           st  <= S_DONE;
                    else if (lat != 8'hFF) lat <= lat + 8'd1;
                end
                default: st <= S_DONE;
            endcase
        end
    end

    // Flag conditions for this cycle; the top latches them.
    always_comb begin
        in_flight     = (st == S_FLIGHT);
        push_ok       = push_hit && (st == S_IDLE);
        pop_ok        = pop_hit && (st == S_FLIGHT);
        set_causality = pop_hit && (st == S_IDLE);
        set_dup       = pop_hit && (st == S_DONE);
        set_latency   = (st == S_FLIGHT) && !pop_hit && (lat >= 8'(MAX_LAT));
        set_env       = push_other || (push_hit && st != S_IDLE);
    end
endmodule

module fv_sb_wolper_mc #(
    parameter int DWIDTH  = 4,
    parameter int NCH     = 2,
    parameter int MAX_LAT = 16,
    parameter int ORDERED = 1,
    parameter int SCW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        push_valid,
    input  logic [NCH*DWIDTH-1:0] push_data,
    input  logic [NCH-1:0]        pop_valid,
    input  logic [NCH*DWIDTH-1:0] pop_data,
    input  logic [DWIDTH-1:0]     sym_a,
    input  logic [DWIDTH-1:0]     sym_b,
    input  logic [SCW-1:0]        sym_ch,
    output logic                  err_causality,
    output logic                  err_dup,
    output logic                  err_latency,
    output logic                  err_order,
    output logic                  err_route,
    output logic                  err_env,
    output logic                  err_any,
    output logic                  busy
);
    // Index 0 tracks A, index 1 tracks B.
    logic [1:0][DWIDTH-1:0] syms;
    logic [1:0] in_flight, push_ok, pop_ok, pop_other;
    logic [1:0] set_causality, set_dup, set_latency, set_env;
    logic       b_after_a, order_set;
    logic       unused_a_hits;

    assign syms = {sym_b, sym_a};

    for (genvar k = 0; k < 2; k++) begin : g_trk
        fv_sb_wolper_trk #(
            .DWIDTH (DWIDTH),
            .NCH    (NCH),
            .MAX_LAT(MAX_LAT),
            .SCW    (SCW)
        ) u_trk (
            .clk          (clk),
            .rst          (rst),
            .sym          (syms[k]),
            .sym_ch       (sym_ch),
            .push_valid   (push_valid),
            .push_data    (push_data),
            .pop_valid    (pop_valid),
            .pop_data     (pop_data),
            .in_flight    (in_flight[k]),
            .push_ok      (push_ok[k]),
            .pop_ok       (pop_ok[k]),
            .pop_other    (pop_other[k]),
            .set_causality(set_causality[k]),
            .set_dup      (set_dup[k]),
            .set_latency  (set_latency[k]),
            .set_env      (set_env[k])
        );
    end

    // Order only depends on B's legal push/pop; A's pulses are not needed.
    assign unused_a_hits = ^{push_ok[0], pop_ok[0]};

    // Remember whether B's push landed while A was already in flight,
    // i.e. A was pushed in a strictly earlier cycle.
    always_ff @(posedge clk) begin
        if (rst)             b_after_a <= 1'b0;
        else if (push_ok[1]) b_after_a <= in_flight[0];
    end

    assign order_set = pop_ok[1] && in_flight[0] && b_after_a;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_causality <= 1'b0;
            err_dup       <= 1'b0;
            err_latency   <= 1'b0;
            err_order     <= 1'b0;
            err_route     <= 1'b0;
            err_env       <= 1'b0;
        end else begin
            if (|set_causality) err_causality <= 1'b1;
            if (|set_dup)       err_dup       <= 1'b1;
            if (|set_latency)   err_latency   <= 1'b1;
            if (|pop_other)     err_route     <= 1'b1;
            if (|set_env)       err_env       <= 1'b1;
            if (ORDERED != 0 && order_set) err_order <= 1'b1;
        end
    end

    // Summary outputs straight from registered state.
    always_comb begin
        busy    = |in_flight;
        err_any = err_causality | err_dup | err_latency | err_order | err_route | err_env;
    end

`ifdef FV_SB_WOLPER_ASSERT_EN
    asm_stable: assume property (@(posedge clk) disable iff (rst)
        $stable(sym_a) && $stable(sym_b) && $stable(sym_ch));
    asm_env: assume property (@(posedge clk) disable iff (rst) set_env == 2'b00);
    ast_causality: assert property (@(posedge clk) disable iff (rst) !err_causality);
    ast_dup:       assert property (@(posedge clk) disable iff (rst) !err_dup);
    ast_latency:   assert property (@(posedge clk) disable iff (rst) !err_latency);
    ast_order:     assert property (@(posedge clk) disable iff (rst) !err_order);
    ast_route:     assert property (@(posedge clk) disable iff (rst) !err_route);
    for (genvar k = 0; k < 2; k++) begin : g_live
        cov_done: cover property (@(posedge clk) disable iff (rst)
            push_ok[k] ##1 s_eventually !in_flight[k]);
    end
`else
    // Property-free build: flag logic above is identical either way.
`endif
endmodule

// File: doc/fv_sb_wolper_mc.md
FV_SB_WOLPER_MC -- requirements
Module: fv_sb_wolper_mc

Interface
REQ-001 Parameter DWIDTH, default 4: payload width in bits.
REQ-002 Parameter NCH, default 2: number of push/pop channel pairs, 1..8.
REQ-003 Parameter MAX_LAT, default 16: max cycles allowed from push to pop of a tracked symbol, 1..255.
REQ-004 Parameter ORDERED, default 1: 1 enables in-order check between symbols A and B.
REQ-005 clk  in  1  clock; the block uses this one clock only.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 push_valid  in  NCH  per-channel push strobe.
REQ-008 push_data  in  NCH*DWIDTH  channel i data in bits [i*DWIDTH +: DWIDTH].
REQ-009 pop_valid  in  NCH  per-channel pop strobe.
REQ-010 pop_data  in  NCH*DWIDTH  packed the same way as push_data.
REQ-011 sym_a, sym_b  in  DWIDTH each  tracked symbols, held stable after reset; sym_a != sym_b.
REQ-012 sym_ch  in  $clog2(NCH) (min 1)  channel carrying both symbols, held stable after reset.
REQ-013 err_causality, err_dup, err_latency, err_order, err_route, err_env  out  1 each  sticky error flags.
REQ-014 err_any  out  1  OR of all error flags.
REQ-015 busy  out  1  high while either symbol is IN_FLIGHT.

Function
REQ-016 Each symbol s in {A,B} has an FSM with states IDLE, IN_FLIGHT and DONE, plus an 8-bit latency counter lat_s.
REQ-017 Push of s (push_valid[sym_ch] && push_data[sym_ch]==s) in IDLE: next state IN_FLIGHT, lat_s loads 0.
REQ-018 Pop of s on sym_ch in IN_FLIGHT: next state DONE.
- Pop in the same cycle as the push is not a legal pop; minimum latency is 1 cycle.
REQ-019 Pop of s on sym_ch in IDLE, or in the push cycle: set err_causality; state unchanged.
REQ-020 Pop of s on sym_ch in DONE: set err_dup.
REQ-021 In IN_FLIGHT, lat_s increments each cycle without a pop and saturates at 255.
- err_latency sets on the cycle lat_s reaches MAX_LAT with no pop.
REQ-022 Symbol s on pop_data of any channel other than sym_ch with pop_valid high: set err_route.
REQ-023 Symbol s on push_data of any channel other than sym_ch, or a push of s while not IDLE: set err_env.
- Pushes flagged by err_env do not change FSM state.
REQ-024 With ORDERED=1, A pushed in a strictly earlier cycle than B and B popped while A is IN_FLIGHT: set err_order.
- Same-cycle push of A and B is impossible on one channel.
- Same-cycle pop of A and B on one channel is impossible.
REQ-025 With ORDERED=0, err_order is constant 0.
REQ-026 All flags are registered: each is visible one cycle after the offending input cycle, stays set until rst, and takes priority over no flag (multiple flags may set together).
REQ-027 busy and err_any are combinational from registered state only.
REQ-028 Channels other than sym_ch never change FSM state.

Reset
REQ-029 While rst is high at a clk edge, both FSMs go to IDLE, lat_A and lat_B go to 0, and all err_* outputs and busy go to 0.
REQ-030 Reset mid-flight discards tracking; a later pop of a symbol pushed before reset sets err_causality.

Configuration
REQ-031 Macro FV_SB_WOLPER_ASSERT_EN defined: the block compiles in concurrent properties (disable iff rst).
- Assumptions: sym_a, sym_b and sym_ch are stable; no err_env condition occurs.
- Assertions: !err_causality, !err_dup, !err_latency, !err_order, !err_route.
- Liveness cover: s_eventually DONE for each pushed symbol.
REQ-032 Macro FV_SB_WOLPER_ASSERT_EN undefined: no properties are compiled; the flag outputs behave identically.

Verification
REQ-033 Scenario 1: DWIDTH=4, NCH=2, sym_a=5, sym_ch=1; push 5 on ch1 at cycle 2, pop 5 on ch1 at cycle 6 -> all flags remain 0, busy high during cycles 3-6 and low from cycle 7.
REQ-034 Scenario 2: pop 5 on ch1 with no prior push -> err_causality=1 one cycle later, err_any=1.
REQ-035 Scenario 3: push 5, pop 5 at +3, pop 5 again at +5 -> err_dup=1 only.
REQ-036 Scenario 4: MAX_LAT=4; push 5 with no pop -> err_latency=1 the cycle after lat_A reaches 4.
REQ-037 Scenario 5: ORDERED=1, sym_b=9; push 5 at t, push 9 at t+1, pop 9 at t+3 -> err_order=1; repeat with ORDERED=0 -> err_order stays 0.
REQ-038 Scenario 6: push 5 on ch1, pop 5 on ch0 -> err_route=1; assert rst, then pop 5 on ch1 -> err_causality=1 and err_route=0.
